// File: rtl/gshare_bp_if.sv
// Fetch/resolve/perf-counter bundle between the pipeline (master) and the
// gshare branch predictor (slave).
interface gshare_bp_if #(
  parameter int GHR_BITS  = 5,
  parameter int CNT_WIDTH = 32
);
  logic                 if_valid;
  logic [31:0]          if_pc;
  logic [31:0]          pred_pc;
  logic                 pred_taken;
  logic                 pred_hit;
  logic [GHR_BITS-1:0]  pred_ghr;

  logic                 res_valid;
  logic                 res_is_cond;
  logic [31:0]          res_pc;
  logic                 res_taken;
  logic [31:0]          res_target;
  logic [GHR_BITS-1:0]  res_ghr;
  logic                 res_hit;
  logic                 res_mispredict;

  logic [CNT_WIDTH-1:0] br_count;
  logic [CNT_WIDTH-1:0] mp_count;

  modport master (
    output if_valid, if_pc,
    output res_valid, res_is_cond, res_pc, res_taken, res_target,
    output res_ghr, res_hit, res_mispredict,
    input  pred_pc, pred_taken, pred_hit, pred_ghr,
    input  br_count, mp_count
  );

  modport slave (
    input  if_valid, if_pc,
    input  res_valid, res_is_cond, res_pc, res_taken, res_target,
    input  res_ghr, res_hit, res_mispredict,
    output pred_pc, pred_taken, pred_hit, pred_ghr,
    output br_count, mp_count
  );
endinterface

// File: rtl/gshare_bp.sv
// Gshare predictor with BTB and speculative global history: combinational
// prediction at fetch, PHT/BTB training and history repair at ID resolve.
module gshare_bp #(
  parameter int BTB_IDX_BITS = 5,
  parameter int PHT_IDX_BITS = 5,
  parameter int GHR_BITS     = 5,
  parameter int CTR_INIT     = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic       clk,
  input  logic       reset,
  gshare_bp_if.slave bp
);

  localparam int BTB_N    = 1 << BTB_IDX_BITS;
  localparam int PHT_N    = 1 << PHT_IDX_BITS;
  localparam int TAG_BITS = 30 - BTB_IDX_BITS;

  logic                 btbValid_q  [BTB_N];
  logic [TAG_BITS-1:0]  btbTag_q    [BTB_N];
  logic [31:0]          btbTarget_q [BTB_N];
  logic                 btbCond_q   [BTB_N];
  logic [1:0]           pht_q       [PHT_N];
  logic [GHR_BITS-1:0]  ghr_q, ghr_d;
  logic [CNT_WIDTH-1:0] brCount_q, brCount_d;
  logic [CNT_WIDTH-1:0] mpCount_q, mpCount_d;

  logic [BTB_IDX_BITS-1:0] fetchBtbIdx;
  logic [TAG_BITS-1:0]     fetchTag;
  logic [PHT_IDX_BITS-1:0] fetchPhtIdx;
  logic                    fetchHit;
  logic                    fetchCond;
  logic                    fetchTaken;

  logic [BTB_IDX_BITS-1:0] resBtbIdx;
  logic [TAG_BITS-1:0]     resTag;
  logic [PHT_IDX_BITS-1:0] resPhtIdx;
  logic [1:0]              unusedResPcLow;

  assign fetchBtbIdx = bp.if_pc[BTB_IDX_BITS+1:2];
  assign fetchTag    = bp.if_pc[31:BTB_IDX_BITS+2];
  assign fetchPhtIdx = bp.if_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_q);
  assign fetchHit    = btbValid_q[fetchBtbIdx] && (btbTag_q[fetchBtbIdx] == fetchTag);
  assign fetchCond   = btbCond_q[fetchBtbIdx];
  assign fetchTaken  = fetchHit && (!fetchCond || pht_q[fetchPhtIdx][1]);

  assign bp.pred_hit   = fetchHit;
  assign bp.pred_taken = fetchTaken;
  assign bp.pred_pc    = fetchTaken ? btbTarget_q[fetchBtbIdx] : bp.if_pc + 32'd4;
  assign bp.pred_ghr   = ghr_q;
  assign bp.br_count   = brCount_q;
  assign bp.mp_count   = mpCount_q;

  assign resBtbIdx      = bp.res_pc[BTB_IDX_BITS+1:2];
  assign resTag         = bp.res_pc[31:BTB_IDX_BITS+2];
  assign resPhtIdx      = bp.res_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(bp.res_ghr);
  assign unusedResPcLow = bp.res_pc[1:0];

  // Truncating {history, bit} drops the oldest bit, which also covers GHR_BITS == 1.
  // A resolve-side repair is written last so it always beats the fetch shift.
  always_comb begin
    ghr_d     = ghr_q;
    brCount_d = brCount_q;
    mpCount_d = mpCount_q;
    if (bp.if_valid && fetchHit && fetchCond)
      ghr_d = GHR_BITS'({ghr_q, fetchTaken});
    if (bp.res_valid) begin
      if (bp.res_is_cond && (bp.res_mispredict || !bp.res_hit))
        ghr_d = GHR_BITS'({bp.res_ghr, bp.res_taken});
      else if (!bp.res_is_cond && bp.res_mispredict)
        ghr_d = bp.res_ghr;
      if (bp.res_is_cond && (brCount_q != '1))
        brCount_d = brCount_q + CNT_WIDTH'(1);
      if (bp.res_mispredict && (mpCount_q != '1))
        mpCount_d = mpCount_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_N; i++) btbValid_q[i] <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'(CTR_INIT);
      ghr_q     <= '0;
      brCount_q <= '0;
      mpCount_q <= '0;
    end else begin
      if (bp.res_valid && bp.res_is_cond) begin
        if (bp.res_taken && (pht_q[resPhtIdx] != 2'd3))
          pht_q[resPhtIdx] <= pht_q[resPhtIdx] + 2'd1;
        else if (!bp.res_taken && (pht_q[resPhtIdx] != 2'd0))
          pht_q[resPhtIdx] <= pht_q[resPhtIdx] - 2'd1;
      end
      if (bp.res_valid && bp.res_taken)
        btbValid_q[resBtbIdx] <= 1'b1;
      ghr_q     <= ghr_d;
      brCount_q <= brCount_d;
      mpCount_q <= mpCount_d;
    end
  end

  // Payload fields need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (bp.res_valid && bp.res_taken) begin
      btbTag_q[resBtbIdx]    <= resTag;
      btbTarget_q[resBtbIdx] <= bp.res_target;
      btbCond_q[resBtbIdx]   <= bp.res_is_cond;
    end
  end

endmodule
